mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, sitting in the EX stage beside the ALU of the pipelined CPU. It accepts one operation per start pulse, raises `busy` for a fixed, operation-dependent number of cycles, then commits the result to `hi`/`lo`. The hazard unit stalls dependent MFHI/MFLO/MULT/DIV instructions on `start | busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (>=1).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (>=1).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled with `op`, `a`, `b`.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- `a`  in  WIDTH  rs operand / dividend / MTHI-MTLO data.
- `b`  in  WIDTH  rt operand / divisor.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in flight.

## Operation
- FSM states: IDLE, RUN. Reset -> IDLE, `hi`=0, `lo`=0, `busy`=0, counter=0, pending result cleared.
- IDLE, `start`, op MULT/MULTU/DIV/DIVU: compute result into shadow `{res_hi,res_lo}`, load counter with MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, `start`, op MTHI/MTLO: write `a` to `hi`/`lo` at that edge; stay IDLE; `busy` stays 0.
- IDLE, `start`, op 11x, or no `start`: no change.
- RUN: counter decrements each edge; on the edge where counter reaches 0 (was 1), commit shadow to `hi`/`lo`, go IDLE.
- `start` while RUN is ignored entirely (no MTHI/MTLO either); HI/LO visible values unchanged until commit.
- MULT: signed 2*WIDTH product; `hi`=upper WIDTH bits, `lo`=lower. MULTU: unsigned.
- DIV: `lo`=quotient truncated toward zero, `hi`=remainder with dividend sign. DIVU: unsigned.
- Signed overflow (MIN / -1): `lo`=MIN, `hi`=0.
- Divide by zero (DIV or DIVU): `hi`=`a`, `lo`=all ones; still takes DIV_CYCLES.
- Reset mid-RUN: immediate return to IDLE, `busy`=0, `hi`=`lo`=0, shadow discarded; no later commit.

## Timing
- `busy` is registered: start sampled at edge E0 -> `busy`=1 after E0 through edge E0+N, where N is the op latency; `hi`/`lo` change and `busy` falls at edge E0+N simultaneously.
- A new `start` is accepted at edge E0+N+1 at earliest (busy low during the preceding cycle); back-to-back with no bubble is not supported.
- MTHI/MTLO: `hi`/`lo` valid one edge after start, zero busy cycles.
- `hi`/`lo` are plain registers, no combinational path from inputs.

## Structure
- Shared package `mdu_pkg`: op encoding constants (`MDU_MULT`..`MDU_MTLO`), FSM state enum `{IDLE, RUN}`.
- One natural sub-module: `mdu_compute` — combinational, parametrised by WIDTH; takes `op`, `a`, `b`, returns `{res_hi,res_lo}` including divide-by-zero and overflow rules. Top holds FSM, counter, shadow and HI/LO registers.
- Counter width `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`.

## Test plan
(WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
- MULT a=0xFFFFFFFD, b=7 -> `busy` high exactly 5 cycles; at fall `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; values unchanged before.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU a=7, b=2 -> `lo`=3, `hi`=1; DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MTHI a=0x1234 while idle -> `hi`=0x1234 next edge, `busy` never rises; MULT started, then MTLO and DIV `start` during busy -> both ignored, only MULT result commits.
- DIVU a=0x55, b=0 -> after 10 cycles `hi`=0x55, `lo`=0xFFFFFFFF.
- DIV started, `reset` pulsed asynchronously in busy cycle 4 -> `busy`, `hi`, `lo` go 0 without waiting for clk, and stay 0 through cycle 12.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and FSM states.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_compute.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU, including
// the divide-by-zero and signed-overflow corner cases.
module mdu_compute
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] prodSigned;
    logic [2*WIDTH-1:0] prodUnsigned;
    logic               divSigned;
    logic               negA;
    logic               negB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH-1:0]   quotMag;
    logic [WIDTH-1:0]   remMag;
    logic               divByZero;
    logic               overflow;

    assign prodSigned   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prodUnsigned = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed division works on magnitudes; signs are reapplied afterwards.
    assign divSigned = (op == MDU_DIV);
    assign negA      = divSigned & a[WIDTH-1];
    assign negB      = divSigned & b[WIDTH-1];
    assign absA      = negA ? -a : a;
    assign absB      = negB ? -b : b;
    assign divByZero = (b == '0);
    assign overflow  = divSigned && (a == MinVal) && (b == '1);
    assign quotMag   = divByZero ? '0 : absA / absB;
    assign remMag    = divByZero ? '0 : absA % absB;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MDU_MULT: begin
                res_hi = prodSigned[2*WIDTH-1:WIDTH];
                res_lo = prodSigned[WIDTH-1:0];
            end
            MDU_MULTU: begin
                res_hi = prodUnsigned[2*WIDTH-1:WIDTH];
                res_lo = prodUnsigned[WIDTH-1:0];
            end
            MDU_DIV, MDU_DIVU: begin
                if (divByZero) begin
                    res_hi = a;
                    res_lo = '1;
                end else if (overflow) begin
                    res_hi = '0;
                    res_lo = MinVal;
                end else begin
                    res_lo = (negA ^ negB) ? -quotMag : quotMag;
                    res_hi = negA ? -remMag : remMag;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: computes into a shadow register, holds
// busy for a fixed op-dependent latency, then commits to HI/LO.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CntW      = $clog2(MaxCycles + 1);

    mdu_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] resHi_q, resHi_d;
    logic [WIDTH-1:0] resLo_q, resLo_d;
    logic [WIDTH-1:0] compHi;
    logic [WIDTH-1:0] compLo;

    mdu_compute #(
        .WIDTH(WIDTH)
    ) uCompute (
        .op    (op),
        .a     (a),
        .b     (b),
        .res_hi(compHi),
        .res_lo(compLo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            resHi_q <= '0;
            resLo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            resHi_q <= resHi_d;
            resLo_q <= resLo_d;
        end
    end

    // Requests are only accepted in IDLE; anything arriving during RUN is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        resHi_d = resHi_q;
        resLo_d = resLo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            resHi_d = compHi;
                            resLo_d = compLo;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            resHi_d = compHi;
                            resLo_d = compLo;
                            cnt_d   = CntW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CntW'(1)) begin
                    hi_d    = resHi_q;
                    lo_d    = resLo_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cycles;
    logic sawNonZero;

    mul_div_unit #(
        .WIDTH      (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .hi   (hi),
        .lo   (lo),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; start is sampled at the next posedge.
    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
        a     = '0;
        b     = '0;
    endtask

    // Counts negedges on which busy is high; bounded so a stuck unit still ends.
    task automatic waitIdle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b111;
        a     = '0;
        b     = '0;
        #12;
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // MULT -3 * 7 = -21
        applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd7);
        checkOutput("mult_busy_rise", {31'b0, busy}, 32'h1);
        checkOutput("mult_hi_hold", hi, 32'h0);
        checkOutput("mult_lo_hold", lo, 32'h0);
        waitIdle(cycles);
        checkOutput("mult_cycles", cycles, 32'd5);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFEB);

        // MULTU 0xFFFFFFFF * 2
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'd2);
        waitIdle(cycles);
        checkOutput("multu_cycles", cycles, 32'd5);
        checkOutput("multu_hi", hi, 32'h0000_0001);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFE);

        // DIV -7 / 2
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_hi_hold", hi, 32'h0000_0001);
        waitIdle(cycles);
        checkOutput("div_cycles", cycles, 32'd10);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        applyStimulus(3'b011, 32'd7, 32'd2);
        waitIdle(cycles);
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);

        // DIV overflow MIN / -1
        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(cycles);
        checkOutput("ovf_cycles", cycles, 32'd10);
        checkOutput("ovf_lo", lo, 32'h8000_0000);
        checkOutput("ovf_hi", hi, 32'h0);

        // MTHI while idle
        applyStimulus(3'b100, 32'h0000_1234, 32'h0);
        checkOutput("mthi_hi", hi, 32'h0000_1234);
        checkOutput("mthi_busy", {31'b0, busy}, 32'h0);
        checkOutput("mthi_lo_keep", lo, 32'h8000_0000);
        @(negedge clk);
        checkOutput("mthi_busy_later", {31'b0, busy}, 32'h0);

        // No-op 11x changes nothing
        applyStimulus(3'b110, 32'hAAAA_AAAA, 32'h5);
        checkOutput("noop_hi", hi, 32'h0000_1234);
        checkOutput("noop_lo", lo, 32'h8000_0000);
        checkOutput("noop_busy", {31'b0, busy}, 32'h0);

        // MULT 3*4 with MTLO and DIV requests dropped while busy
        applyStimulus(3'b000, 32'd3, 32'd4);
        applyStimulus(3'b101, 32'h0000_DEAD, 32'h0);
        checkOutput("ign_lo_hold", lo, 32'h8000_0000);
        checkOutput("ign_hi_hold", hi, 32'h0000_1234);
        applyStimulus(3'b010, 32'd100, 32'd7);
        waitIdle(cycles);
        checkOutput("ign_rest_cycles", cycles, 32'd3);
        checkOutput("ign_hi", hi, 32'h0);
        checkOutput("ign_lo", lo, 32'd12);
        @(negedge clk);
        checkOutput("ign_no_div", {31'b0, busy}, 32'h0);

        // MTLO while idle
        applyStimulus(3'b101, 32'h0000_BEEF, 32'h0);
        checkOutput("mtlo_lo", lo, 32'h0000_BEEF);

        // DIVU by zero
        applyStimulus(3'b011, 32'h0000_0055, 32'h0);
        waitIdle(cycles);
        checkOutput("dz_cycles", cycles, 32'd10);
        checkOutput("dz_hi", hi, 32'h0000_0055);
        checkOutput("dz_lo", lo, 32'hFFFF_FFFF);

        // Reset asynchronously in busy cycle 4 of a DIV
        applyStimulus(3'b010, 32'd50, 32'd3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy_before", {31'b0, busy}, 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_busy_async", {31'b0, busy}, 32'h0);
        checkOutput("rst_hi_async", hi, 32'h0);
        checkOutput("rst_lo_async", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        sawNonZero = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) sawNonZero = 1'b1;
        end
        checkOutput("rst_no_commit", {31'b0, sawNonZero}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
